// File: rtl/uart_tx_module.sv
// 8N1 UART transmitter, LSB first, with a tx_en_sig/tx_done_sig handshake.
// Line output and status flags are registered; the FSM waits in RELEASE until enable drops.
module uart_tx_module #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       tx_en_sig,
  input  logic [7:0] tx_data,
  output logic       tx_done_sig,
  output logic       tx_busy,
  output logic       tx_pin_out
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_pin, w_pin_nxt;
  logic          r_done, w_done_nxt;
  logic          r_busy, w_busy_nxt;
  logic          w_bit_end;
  logic [2:0]    w_idx_inc;

  assign w_bit_end = (r_cnt == CNT_MAX);
  assign w_idx_inc = r_idx + 3'd1;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_pin   <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_pin   <= w_pin_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Each output is computed one cycle ahead so the registered line changes on the bit edge itself.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_pin_nxt   = r_pin;
    w_done_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    unique case (r_state)
      S_IDLE: begin
        w_pin_nxt = 1'b1;
        if (tx_en_sig) begin
          w_shift_nxt = tx_data;
          w_pin_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_pin_nxt   = r_shift[0];
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_idx == 3'd7) begin
            w_pin_nxt   = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = w_idx_inc;
            w_pin_nxt = r_shift[w_idx_inc];
          end
        end
      end
      S_STOP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        w_busy_nxt = 1'b0;
        if (!tx_en_sig) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pin_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign tx_pin_out  = r_pin;
  assign tx_done_sig = r_done;
  assign tx_busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_module.sv
// Self-checking bench for uart_tx_module at BAUD_DIV=4: vector table, reset corners, random frames.
module tb_uart_tx_module;

  localparam int DIV = 4;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       tx_en_sig = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_done_sig, tx_busy, tx_pin_out;

  int total = 0;
  int bad   = 0;

  uart_tx_module #(.CLK_FREQ(1_000_000), .BAUD_RATE(250_000)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .tx_en_sig   (tx_en_sig),
    .tx_data     (tx_data),
    .tx_done_sig (tx_done_sig),
    .tx_busy     (tx_busy),
    .tx_pin_out  (tx_pin_out)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [7:0] data;
    int         hold;     // 0: controller style, >0: clocks high, <0: held long past done
    int         chg_at;   // frame clock at which tx_data is overwritten, -1 none
    logic [7:0] chg_val;
    logic [9:0] exp_frame; // line bits in time order, index 0 first: start, d0..d7, stop
  } vec_t;

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_frame(input logic [7:0] d, input int hold, input int chg_at,
                           input logic [7:0] chg_val, input logic [9:0] ef);
    logic [7:0] rx;
    rx = '0;
    tx_data   = d;
    tx_en_sig = 1'b1;
    for (int k = 0; k < 10 * DIV; k++) begin
      @(negedge sysclk);
      if (hold > 0 && k == hold - 1) tx_en_sig = 1'b0;
      if (k == chg_at) tx_data = chg_val;
      chk("line", int'(tx_pin_out), int'(ef[k / DIV]));
      chk("busy_frame", int'(tx_busy), 1);
      chk("done_early", int'(tx_done_sig), 0);
      if (k % DIV == DIV / 2 && k / DIV >= 1 && k / DIV <= 8) rx[k / DIV - 1] = tx_pin_out;
    end
    @(negedge sysclk);
    chk("done_pulse", int'(tx_done_sig), 1);
    chk("busy_done", int'(tx_busy), 1);
    chk("line_done", int'(tx_pin_out), 1);
    @(negedge sysclk);
    chk("done_once", int'(tx_done_sig), 0);
    chk("busy_release", int'(tx_busy), 0);
    chk("line_release", int'(tx_pin_out), 1);
    if (hold == 0) tx_en_sig = 1'b0;
    if (hold < 0) begin
      for (int j = 0; j < 8; j++) begin
        @(negedge sysclk);
        chk("no_retrigger_line", int'(tx_pin_out), 1);
        chk("no_retrigger_busy", int'(tx_busy), 0);
        chk("no_retrigger_done", int'(tx_done_sig), 0);
      end
      tx_en_sig = 1'b0;
    end
    @(negedge sysclk);
    chk("idle_line", int'(tx_pin_out), 1);
    chk("idle_busy", int'(tx_busy), 0);
    chk("rx_byte", int'(rx), int'(d));
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h55, 0, -1, 8'h00, {1'b1, 8'h55, 1'b0}};
    vecs[1] = '{8'hA3, 0, 10, 8'hFF, {1'b1, 8'hA3, 1'b0}};
    vecs[2] = '{8'h0F, 2, -1, 8'h00, {1'b1, 8'h0F, 1'b0}};
    vecs[3] = '{8'h00, 0, -1, 8'h00, {1'b1, 8'h00, 1'b0}};
    vecs[4] = '{8'hFF, 0, -1, 8'h00, {1'b1, 8'hFF, 1'b0}};
    vecs[5] = '{8'h81, 0, -1, 8'h00, {1'b1, 8'h81, 1'b0}};
    vecs[6] = '{8'h96, -1, 25, 8'h00, {1'b1, 8'h96, 1'b0}};

    // Reset held for 3 clocks
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      chk("rst_line", int'(tx_pin_out), 1);
      chk("rst_done", int'(tx_done_sig), 0);
      chk("rst_busy", int'(tx_busy), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge sysclk);
      chk("post_rst_line", int'(tx_pin_out), 1);
      chk("post_rst_busy", int'(tx_busy), 0);
      chk("post_rst_done", int'(tx_done_sig), 0);
    end

    foreach (vecs[i])
      run_frame(vecs[i].data, vecs[i].hold, vecs[i].chg_at, vecs[i].chg_val, vecs[i].exp_frame);

    // Reset in the middle of a 0x3C frame
    tx_data   = 8'h3C;
    tx_en_sig = 1'b1;
    repeat (17) @(negedge sysclk);
    chk("pre_abort_busy", int'(tx_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_line", int'(tx_pin_out), 1);
    chk("abort_busy", int'(tx_busy), 0);
    tx_en_sig = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge sysclk);
      chk("abort_done", int'(tx_done_sig), 0);
      chk("abort_line_hold", int'(tx_pin_out), 1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      chk("abort_idle_line", int'(tx_pin_out), 1);
      chk("abort_idle_done", int'(tx_done_sig), 0);
    end
    run_frame(8'hC3, 0, -1, 8'h00, {1'b1, 8'hC3, 1'b0});

    // Random frames against the line-level model
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      int         hold;
      int         chg;
      d = 8'($urandom);
      case ($urandom_range(0, 2))
        0: hold = 0;
        1: hold = int'($urandom_range(1, 39));
        default: hold = -1;
      endcase
      chg = int'($urandom_range(0, 39));
      run_frame(d, hold, chg, 8'($urandom), frame_of(d));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) begin
        @(negedge sysclk);
        chk("gap_line", int'(tx_pin_out), 1);
        chk("gap_busy", int'(tx_busy), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
